// File: rtl/tile_row_fetcher.sv
// tile_row_fetcher: reads one 8-pixel row of a packed 4bpp 8x8 tile from the shared system
// RAM and streams it out one nibble per accepted valid/ready beat.
//
// A tile is 32 bytes, 4 bytes per row, high nibble = left pixel. All address arithmetic
// wraps modulo 2^AddrBits.
//
// Optional feature macro: TILE_ROW_FETCHER_FLIP_EN adds input flipX (latched at start) that
// reverses the emitted pixel order. Without the macro the block behaves as flipX tied 0.
//
// Ports:
//   clk         system clock, all state on posedge
//   reset       asynchronous active-high reset
//   start       request a row fetch (sampled only when idle)
//   tileAddr    base byte address of the tile
//   row         tile row 0..7
//   flipX       (macro builds only) reverse pixel order for this row
//   busy        high whenever a fetch/emit is in progress
//   ramRead     RAM access request
//   ramAddress  RAM byte address (0 when not requesting)
//   ramGrant    arbiter grant; ramData is valid in the same cycle
//   ramData     RAM read data
//   pixel       current pixel colour index
//   pixelValid  pixel is valid
//   pixelReady  consumer accepts pixel
//   rowDone     one-cycle pulse after the 8th pixel is accepted
module tile_row_fetcher #(
    parameter int unsigned AddrBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AddrBits-1:0] tileAddr,
    input  logic [2:0]          row,
`ifdef TILE_ROW_FETCHER_FLIP_EN
    input  logic                flipX,
`endif
    output logic                busy,
    output logic                ramRead,
    output logic [AddrBits-1:0] ramAddress,
    input  logic                ramGrant,
    input  logic [7:0]          ramData,
    output logic [3:0]          pixel,
    output logic                pixelValid,
    input  logic                pixelReady,
    output logic                rowDone
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StEmit
    } state_e;

    state_e              state_q, state_d;
    logic [AddrBits-1:0] base_q, base_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [2:0]          pix_idx_q, pix_idx_d;
    logic [3:0][7:0]     row_buf_q, row_buf_d;
    logic                flip_q, flip_d;
    logic                row_done_q, row_done_d;
    logic                flip_in;
    logic [2:0]          pix_sel;

`ifdef TILE_ROW_FETCHER_FLIP_EN
    assign flip_in = flipX;
`else
    assign flip_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            byte_idx_q <= '0;
            pix_idx_q  <= '0;
            row_buf_q  <= '0;
            flip_q     <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            byte_idx_q <= byte_idx_d;
            pix_idx_q  <= pix_idx_d;
            row_buf_q  <= row_buf_d;
            flip_q     <= flip_d;
            row_done_q <= row_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        byte_idx_d = byte_idx_q;
        pix_idx_d  = pix_idx_q;
        row_buf_d  = row_buf_q;
        flip_d     = flip_q;
        row_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    // Row offset is row*4 bytes; the sum wraps at the address width.
                    base_d     = tileAddr + AddrBits'({row, 2'b00});
                    byte_idx_d = '0;
                    pix_idx_d  = '0;
                    flip_d     = flip_in;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                // Without a grant the request, address and index simply hold.
                if (ramGrant) begin
                    row_buf_d[byte_idx_q] = ramData;
                    byte_idx_d            = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (pixelReady) begin
                    pix_idx_d = pix_idx_q + 3'd1;
                    if (pix_idx_q == 3'd7) begin
                        state_d    = StIdle;
                        row_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the current state so reset clears them immediately.
    always_comb begin
        busy       = (state_q != StIdle);
        ramRead    = (state_q == StFetch);
        ramAddress = '0;
        pixelValid = (state_q == StEmit);
        pixel      = 4'h0;
        rowDone    = row_done_q;
        // Reversed order is just the bit-inverted pixel index (7-i).
        pix_sel    = pix_idx_q ^ {3{flip_q}};
        if (state_q == StFetch) begin
            ramAddress = base_q + AddrBits'(byte_idx_q);
        end
        if (state_q == StEmit) begin
            pixel = pix_sel[0] ? row_buf_q[pix_sel[2:1]][3:0] : row_buf_q[pix_sel[2:1]][7:4];
        end
    end

endmodule

// File: tb/tb_tile_row_fetcher.sv
module tb_tile_row_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] tileAddr;
    logic [2:0]  row;
    logic        flipX;
    logic        busy;
    logic        ramRead;
    logic [15:0] ramAddress;
    logic        ramGrant;
    logic [7:0]  ramData;
    logic [3:0]  pixel;
    logic        pixelValid;
    logic        pixelReady;
    logic        rowDone;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign ramData = mem[ramAddress];

    tile_row_fetcher #(.AddrBits(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tileAddr  (tileAddr),
        .row       (row),
`ifdef TILE_ROW_FETCHER_FLIP_EN
        .flipX     (flipX),
`endif
        .busy      (busy),
        .ramRead   (ramRead),
        .ramAddress(ramAddress),
        .ramGrant  (ramGrant),
        .ramData   (ramData),
        .pixel     (pixel),
        .pixelValid(pixelValid),
        .pixelReady(pixelReady),
        .rowDone   (rowDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 reading bytes, 2 handing out pixels; cnt counts bytes or pixels done.
    int          m_phase;
    int          m_cnt;
    logic [15:0] m_base;
    logic        m_flip;
    logic        m_done;
    logic        flip_eff;

`ifdef TILE_ROW_FETCHER_FLIP_EN
    assign flip_eff = flipX;
`else
    assign flip_eff = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_base  <= 16'h0;
            m_flip  <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_phase == 0 && start) begin
                m_base  <= tileAddr + 16'({row, 2'b00});
                m_flip  <= flip_eff;
                m_cnt   <= 0;
                m_phase <= 1;
            end else if (m_phase == 1 && ramGrant) begin
                m_cnt   <= (m_cnt == 3) ? 0 : m_cnt + 1;
                m_phase <= (m_cnt == 3) ? 2 : 1;
            end else if (m_phase == 2 && pixelReady) begin
                m_cnt   <= (m_cnt == 7) ? 0 : m_cnt + 1;
                m_phase <= (m_cnt == 7) ? 0 : 2;
                m_done  <= (m_cnt == 7);
            end
        end
    end

    // Pixel k of the row comes straight from RAM: byte k/2, high nibble for even k.
    function automatic logic [3:0] model_pixel(input logic [15:0] base, input int n, input logic f);
        int          k;
        logic [7:0]  b;
        k = f ? 7 - n : n;
        b = mem[base + 16'(k / 2)];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // ---------------- compare + recording ----------------
    logic [15:0] cap_q[$];
    logic [3:0]  pix_q[$];
    int          done_cnt;

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("ramRead", 32'(ramRead), 32'(m_phase == 1));
            check("ramAddress", 32'(ramAddress),
                  (m_phase == 1) ? 32'(m_base + 16'(m_cnt)) : 32'h0);
            check("pixelValid", 32'(pixelValid), 32'(m_phase == 2));
            check("rowDone", 32'(rowDone), 32'(m_done));
            if (m_phase == 2) check("pixel", 32'(pixel), 32'(model_pixel(m_base, m_cnt, m_flip)));
            // Inputs only change just after posedge, so these record what the next edge takes.
            if (ramRead && ramGrant) cap_q.push_back(ramAddress);
            if (pixelValid && pixelReady) pix_q.push_back(pixel);
            if (rowDone) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        cap_q.delete();
        pix_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [2:0] r, input logic f);
        tileAddr = a;
        row      = r;
        flipX    = f;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) tick();
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] exp);
        check({tag, "_npix"}, 32'(pix_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < pix_q.size(); i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(pix_q[i]), 32'(exp[31-4*i -: 4]));
    endtask

    task automatic check_addrs(input string tag, input logic [15:0] first);
        check({tag, "_ncap"}, 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(cap_q[i]), 32'(first + 16'(i)));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [6:0] gpat;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h2004] = 8'h77; mem[16'h2005] = 8'h11; mem[16'h2006] = 8'h11; mem[16'h2007] = 8'h11;
        mem[16'h2000] = 8'h01; mem[16'h2001] = 8'h10; mem[16'h2002] = 8'h01; mem[16'h2003] = 8'h10;
        mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h56; mem[16'h0003] = 8'h78;

        reset = 1'b1; start = 1'b0; tileAddr = 16'h0; row = 3'd0; flipX = 1'b0;
        ramGrant = 1'b1; pixelReady = 1'b1;
        done_cnt = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ramRead", 32'(ramRead), 32'd0);
        check("rst_ramAddress", 32'(ramAddress), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_pixelValid", 32'(pixelValid), 32'd0);
        check("rst_rowDone", 32'(rowDone), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // 1: row 1 of 0x2000, continuous grant and ready
        clear_rec();
        do_start(16'h2000, 3'd1, 1'b0);
        check("t1_first_addr", 32'(ramAddress), 32'h2004);
        repeat (3) tick();
        check("t1_valid_before", 32'(pixelValid), 32'd0);
        tick();
        check("t1_valid_first", 32'(pixelValid), 32'd1);
        wait_done("t1");
        check_addrs("t1", 16'h2004);
        check_stream("t1", 32'h77111111);

        // 2: same row, grant pattern 1,0,0,1,0,1,1
        clear_rec();
        gpat = 7'b1001011;
        do_start(16'h2000, 3'd1, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            ramGrant = gpat[i];
            tick();
        end
        ramGrant = 1'b1;
        wait_done("t2");
        check_addrs("t2", 16'h2004);
        check_stream("t2", 32'h77111111);

        // 3: row 0, consumer stalls 3 cycles on the 4th pixel (value 0)
        clear_rec();
        do_start(16'h2000, 3'd0, 1'b0);
        repeat (7) tick();
        pixelReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_stall_pix%0d", i), 32'(pixel), 32'd0);
            check($sformatf("t3_stall_valid%0d", i), 32'(pixelValid), 32'd1);
            tick();
        end
        pixelReady = 1'b1;
        wait_done("t3");
        check_stream("t3", 32'h01100110);

        // 4: base wraps past 0xFFFF
        clear_rec();
        do_start(16'hFFFC, 3'd1, 1'b0);
        wait_done("t4");
        check_addrs("t4", 16'h0000);
        check_stream("t4", 32'h12345678);

        // 5a: start during FETCH is ignored
        clear_rec();
        do_start(16'h2000, 3'd1, 1'b0);
        ramGrant = 1'b0;
        tick();
        tileAddr = 16'h3000; row = 3'd0; start = 1'b1;
        tick();
        start = 1'b0; ramGrant = 1'b1;
        wait_done("t5");
        check_addrs("t5", 16'h2004);
        check_stream("t5", 32'h77111111);

        // 5b: reset mid-EMIT aborts with no rowDone
        clear_rec();
        do_start(16'h2000, 3'd1, 1'b0);
        repeat (6) tick();
        check("t5b_in_emit", 32'(pixelValid), 32'd1);
        reset = 1'b1;
        #1;
        check("t5b_busy", 32'(busy), 32'd0);
        check("t5b_ramRead", 32'(ramRead), 32'd0);
        check("t5b_ramAddress", 32'(ramAddress), 32'd0);
        check("t5b_pixel", 32'(pixel), 32'd0);
        check("t5b_pixelValid", 32'(pixelValid), 32'd0);
        check("t5b_rowDone", 32'(rowDone), 32'd0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("t5b_no_done", 32'(done_cnt), 32'd0);

        // 5c: clean fetch after the abort
        clear_rec();
        do_start(16'h2000, 3'd1, 1'b0);
        wait_done("t5c");
        check_addrs("t5c", 16'h2004);
        check_stream("t5c", 32'h77111111);

`ifdef TILE_ROW_FETCHER_FLIP_EN
        // 6: reversed order
        clear_rec();
        do_start(16'h2000, 3'd1, 1'b1);
        flipX = 1'b0;
        wait_done("t6");
        check_addrs("t6", 16'h2004);
        check_stream("t6", 32'h11111177);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
